// File: rtl/mig_pkg.sv
// rtl/mig_pkg.sv - shared FSM encoding, sentinel constant and counter sizing helper for mig_requester
package mig_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_QUERY = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } mig_state_t;

   // Tracker marks end-of-list with an all-ones address; callers slice to their width.
   localparam logic [63:0] MIG_SENTINEL = '1;

   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wrap-bit pointers and a zeroed read port when empty
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = i_rd_en && !w_empty;
   // A pop in the same cycle frees the slot being written, so push-at-full is safe.
   assign w_push  = i_wr_en && (!w_full || w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
   end

   assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
   assign o_full    = w_full;
   assign o_empty   = w_empty;

endmodule

// File: rtl/mig_requester.sv
// rtl/mig_requester.sv - epoch-driven requester: queries the hot-page tracker, drains its list, issues requests
module mig_requester
   import mig_pkg::*;
#(
   parameter int ADDR_SIZE      = 22,
   parameter int NUM_ENTRY      = 25,
   parameter int EPOCH_CYCLES   = 1000000,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int FIFO_DEPTH     = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   output logic                 query_en,
   input  logic                 query_ready,
   input  logic                 mig_addr_en,
   input  logic [ADDR_SIZE-1:0] mig_addr,
   output logic                 mig_addr_ready,
   output logic                 req_valid,
   output logic [ADDR_SIZE-1:0] req_addr,
   input  logic                 req_ready,
   output logic                 busy,
   output logic [15:0]          mig_count,
   output logic                 timeout_err
);
   localparam int EW = cnt_width(EPOCH_CYCLES);
   localparam int TW = cnt_width(TIMEOUT_CYCLES);
   localparam int DW = cnt_width(NUM_ENTRY);

   localparam logic [EW-1:0] EPOCH_LAST = EW'(EPOCH_CYCLES - 1);
   localparam logic [EW-1:0] EPOCH_ONE  = EW'(1);
   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TO_ONE     = TW'(1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(NUM_ENTRY - 1);
   localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);
   localparam logic [ADDR_SIZE-1:0] SENTINEL = MIG_SENTINEL[ADDR_SIZE-1:0];

   mig_state_t     r_state;
   logic [EW-1:0]  r_epoch_cnt;
   logic [TW-1:0]  r_to_cnt;
   logic [DW-1:0]  r_drain_cnt;
   logic [15:0]    r_mig_count;
   logic           r_timeout_err;

   mig_state_t     w_state_nxt;
   logic [EW-1:0]  w_epoch_nxt;
   logic [TW-1:0]  w_to_nxt;
   logic [DW-1:0]  w_drain_nxt;
   logic           w_query_en;
   logic           w_addr_ready;
   logic           w_push;
   logic           w_set_err;
   logic           w_pop;
   logic           w_fifo_full;
   logic           w_fifo_empty;
   logic [ADDR_SIZE-1:0] w_fifo_head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_epoch_cnt <= '0;
         r_to_cnt    <= '0;
         r_drain_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_epoch_cnt <= w_epoch_nxt;
         r_to_cnt    <= w_to_nxt;
         r_drain_cnt <= w_drain_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_epoch_nxt  = r_epoch_cnt;
      w_to_nxt     = r_to_cnt;
      w_drain_nxt  = r_drain_cnt;
      w_query_en   = 1'b0;
      w_addr_ready = 1'b0;
      w_push       = 1'b0;
      w_set_err    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!enable) begin
               w_epoch_nxt = '0;
            end else if (r_epoch_cnt == EPOCH_LAST) begin
               // Hold at the boundary until the previous epoch's requests are all gone.
               if (w_fifo_empty) begin
                  w_state_nxt = ST_QUERY;
                  w_epoch_nxt = '0;
               end
            end else begin
               w_epoch_nxt = r_epoch_cnt + EPOCH_ONE;
            end
         end
         ST_QUERY: begin
            w_query_en  = 1'b1;
            w_state_nxt = ST_WAIT;
            w_to_nxt    = '0;
         end
         ST_WAIT: begin
            if (query_ready) begin
               w_state_nxt = ST_DRAIN;
               w_to_nxt    = '0;
               w_drain_nxt = '0;
            end else if (r_to_cnt == TO_LAST) begin
               w_state_nxt = ST_IDLE;
               w_to_nxt    = '0;
               w_set_err   = 1'b1;
            end else begin
               w_to_nxt = r_to_cnt + TO_ONE;
            end
         end
         ST_DRAIN: begin
            w_addr_ready = !w_fifo_full;
            if (mig_addr_en && w_addr_ready) begin
               if (mig_addr == SENTINEL) begin
                  w_state_nxt = ST_IDLE;
                  w_drain_nxt = '0;
               end else begin
                  w_push = 1'b1;
                  if (r_drain_cnt == DRAIN_LAST) begin
                     w_state_nxt = ST_IDLE;
                     w_drain_nxt = '0;
                  end else begin
                     w_drain_nxt = r_drain_cnt + DRAIN_ONE;
                  end
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   sync_fifo #(
      .WIDTH (ADDR_SIZE),
      .DEPTH (FIFO_DEPTH)
   ) u_req_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_push),
      .i_wr_data (mig_addr),
      .i_rd_en   (req_ready),
      .o_rd_data (w_fifo_head),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty)
   );

   assign w_pop = !w_fifo_empty && req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mig_count   <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (w_pop && (r_mig_count != 16'hFFFF)) r_mig_count <= r_mig_count + 16'd1;
         if (w_set_err) r_timeout_err <= 1'b1;
      end
   end

   assign query_en       = w_query_en;
   assign mig_addr_ready = w_addr_ready;
   assign req_valid      = !w_fifo_empty;
   assign req_addr       = w_fifo_head;
   assign busy           = (r_state != ST_IDLE) || !w_fifo_empty;
   assign mig_count      = r_mig_count;
   assign timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_mig_requester.sv
// tb/tb_mig_requester.sv - directed table-driven bench for mig_requester with a small tracker model
module tb_mig_requester;
   localparam int AW = 22;
   localparam logic [AW-1:0] SENT = '1;

   logic          clk = 1'b0;
   logic          rst_n, enable, query_en, query_ready, mig_addr_en, mig_addr_ready;
   logic          req_valid, req_ready, busy, timeout_err;
   logic [AW-1:0] mig_addr, req_addr;
   logic [15:0]   mig_count;

   always #5 clk = ~clk;

   mig_requester #(
      .ADDR_SIZE      (AW),
      .NUM_ENTRY      (4),
      .EPOCH_CYCLES   (100),
      .TIMEOUT_CYCLES (16),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .query_en       (query_en),
      .query_ready    (query_ready),
      .mig_addr_en    (mig_addr_en),
      .mig_addr       (mig_addr),
      .mig_addr_ready (mig_addr_ready),
      .req_valid      (req_valid),
      .req_addr       (req_addr),
      .req_ready      (req_ready),
      .busy           (busy),
      .mig_count      (mig_count),
      .timeout_err    (timeout_err)
   );

   typedef struct {
      int            n_in;
      logic [AW-1:0] din [6];
      int            n_out;
      logic [AW-1:0] dout [4];
      int            left;
   } vec_t;

   int            n_tests, n_fail, cyc;
   int            qe_cnt, qe_cyc, qr_delay;
   int            tr_taken, tr_base, rx_base;
   int            rel, e, q0, exp_total;
   bit            tr_silent, s_hs;
   logic [AW-1:0] tr_q [$];
   logic [AW-1:0] rx_q [$];
   logic [AW-1:0] exp_q [$];
   vec_t          vt [5];

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Tracker model and request monitor: samples at negedge, drives 1 time unit after posedge.
   initial begin
      query_ready = 1'b0; mig_addr_en = 1'b0; mig_addr = '0;
      qe_cnt = 0; qe_cyc = 0; qr_delay = 0; tr_taken = 0;
      forever begin
         @(negedge clk);
         s_hs = mig_addr_en && mig_addr_ready;
         if (req_valid && req_ready) rx_q.push_back(req_addr);
         if (query_en) begin
            qe_cnt++;
            qe_cyc = cyc;
            qr_delay = 2;
         end
         @(posedge clk);
         #1;
         if (s_hs) tr_taken++;
         if (qr_delay != 0) begin
            qr_delay--;
            query_ready = (qr_delay == 0) && !tr_silent;
         end else begin
            query_ready = 1'b0;
         end
         mig_addr_en = (tr_taken - tr_base) < tr_q.size();
         mig_addr    = mig_addr_en ? tr_q[tr_taken - tr_base] : '0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic wait_qe(input string nm, input int limit);
      int start = qe_cnt;
      int g = 0;
      while (qe_cnt == start && g < limit) begin
         step(1);
         g++;
      end
      chk(nm, qe_cnt - start, 1);
   endtask

   task automatic wait_idle(input string nm, input int limit);
      int g = 0;
      while (busy && g < limit) begin
         step(1);
         g++;
      end
      chk(nm, {31'd0, busy}, 0);
   endtask

   task automatic load_tracker();
      tr_base = tr_taken;
      rx_base = rx_q.size();
   endtask

   task automatic chk_rx(input string nm);
      int n = rx_q.size() - rx_base;
      chk({nm, "_count"}, n, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < n; i++)
         chk($sformatf("%s_%0d", nm, i), rx_q[rx_base + i], exp_q[i]);
   endtask

   function automatic int tr_left();
      return tr_q.size() - (tr_taken - tr_base);
   endfunction

   initial begin
      vt[0] = '{4, '{22'h10, 22'h20, 22'h30, 22'h40, 22'h0, 22'h0}, 4, '{22'h10, 22'h20, 22'h30, 22'h40}, 0};
      vt[1] = '{2, '{22'h11, 22'h3FFFFF, 22'h0, 22'h0, 22'h0, 22'h0}, 1, '{22'h11, 22'h0, 22'h0, 22'h0}, 0};
      vt[2] = '{2, '{22'h3FFFFF, 22'h55, 22'h0, 22'h0, 22'h0, 22'h0}, 0, '{22'h0, 22'h0, 22'h0, 22'h0}, 1};
      vt[3] = '{5, '{22'h1, 22'h2, 22'h3, 22'h4, 22'h5, 22'h0}, 4, '{22'h1, 22'h2, 22'h3, 22'h4}, 1};
      vt[4] = '{2, '{22'h3FFFFE, 22'h3FFFFF, 22'h0, 22'h0, 22'h0, 22'h0}, 1, '{22'h3FFFFE, 22'h0, 22'h0, 22'h0}, 0};

      n_tests = 0; n_fail = 0; exp_total = 0; tr_base = 0; rx_base = 0;
      tr_silent = 0; rst_n = 1'b0; enable = 1'b1; req_ready = 1'b1;
      step(3);
      chk("rst_query_en", {31'd0, query_en}, 0);
      chk("rst_addr_ready", {31'd0, mig_addr_ready}, 0);
      chk("rst_req_valid", {31'd0, req_valid}, 0);
      chk("rst_req_addr", req_addr, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_mig_count", mig_count, 0);
      chk("rst_timeout_err", {31'd0, timeout_err}, 0);

      @(posedge clk); #1;
      rst_n = 1'b1;
      rel = cyc;

      for (int i = 0; i < 5; i++) begin
         tr_q.delete();
         exp_q.delete();
         for (int j = 0; j < vt[i].n_in; j++) tr_q.push_back(vt[i].din[j]);
         for (int j = 0; j < vt[i].n_out; j++) exp_q.push_back(vt[i].dout[j]);
         load_tracker();
         q0 = qe_cnt;
         wait_qe($sformatf("v%0d_query", i), 200);
         if (i == 0) chk("first_query_cycle", qe_cyc - rel, 100);
         wait_idle($sformatf("v%0d_idle", i), 80);
         chk($sformatf("v%0d_query_pulses", i), qe_cnt - q0, 1);
         chk_rx($sformatf("v%0d_rx", i));
         chk($sformatf("v%0d_left", i), tr_left(), vt[i].left);
         exp_total += vt[i].n_out;
         chk($sformatf("v%0d_mig_count", i), mig_count, exp_total);
      end

      // Backpressure: FIFO fills, tracker keeps the rest, next query waits for empty FIFO.
      req_ready = 1'b0;
      tr_q.delete();
      for (int k = 0; k < 6; k++) tr_q.push_back(22'h61 + 22'(k));
      load_tracker();
      wait_qe("bp_query", 200);
      step(20);
      chk("bp_addr_ready_low", {31'd0, mig_addr_ready}, 0);
      chk("bp_tracker_left", tr_left(), 2);
      chk("bp_req_valid", {31'd0, req_valid}, 1);
      chk("bp_head", req_addr, 22'h61);
      q0 = qe_cnt;
      step(150);
      chk("bp_no_query", qe_cnt - q0, 0);
      chk("bp_head_stable", req_addr, 22'h61);
      tr_q.delete();
      tr_q.push_back(SENT);
      exp_q.delete();
      for (int k = 0; k < 4; k++) exp_q.push_back(22'h61 + 22'(k));
      tr_base = tr_taken;
      @(posedge clk); #1;
      req_ready = 1'b1;
      e = cyc;
      wait_qe("bp_query2", 30);
      chk("bp_query_delay", qe_cyc - e, 5);
      wait_idle("bp_idle", 40);
      chk_rx("bp_rx");
      exp_total += 4;
      chk("bp_mig_count", mig_count, exp_total);

      // Tracker never answers: timeout after 16 WAIT cycles, next epoch still queries.
      tr_silent = 1;
      tr_q.delete();
      load_tracker();
      wait_qe("to_query", 200);
      step(16);
      chk("to_err_early", {31'd0, timeout_err}, 0);
      chk("to_busy_in_wait", {31'd0, busy}, 1);
      step(1);
      chk("to_err_set", {31'd0, timeout_err}, 1);
      chk("to_back_idle", {31'd0, busy}, 0);
      tr_silent = 0;
      tr_q.push_back(22'h77);
      tr_q.push_back(SENT);
      exp_q.delete();
      exp_q.push_back(22'h77);
      load_tracker();
      wait_qe("to_requery", 200);
      wait_idle("to_idle2", 80);
      chk_rx("to_rx");
      exp_total += 1;
      chk("to_mig_count", mig_count, exp_total);
      chk("to_err_sticky", {31'd0, timeout_err}, 1);

      // Reset while DRAIN holds two buffered addresses.
      req_ready = 1'b0;
      tr_q.delete();
      tr_q.push_back(22'h81);
      tr_q.push_back(22'h82);
      load_tracker();
      wait_qe("rst_mid_query", 200);
      step(10);
      chk("rst_mid_pre_valid", {31'd0, req_valid}, 1);
      chk("rst_mid_pre_left", tr_left(), 0);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_req_valid", {31'd0, req_valid}, 0);
      chk("rst_mid_mig_count", mig_count, 0);
      chk("rst_mid_busy", {31'd0, busy}, 0);
      chk("rst_mid_req_addr", req_addr, 0);
      chk("rst_mid_timeout_err", {31'd0, timeout_err}, 0);
      chk("rst_mid_addr_ready", {31'd0, mig_addr_ready}, 0);
      tr_q.delete();
      tr_q.push_back(SENT);
      load_tracker();
      req_ready = 1'b1;
      exp_total = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      rel = cyc;
      wait_qe("rst_mid_requery", 200);
      chk("rst_mid_query_cycle", qe_cyc - rel, 100);
      wait_idle("rst_mid_idle", 40);
      chk("rst_mid_count_after", mig_count, 0);

      // enable drops during WAIT: epoch completes, no further queries.
      tr_q.delete();
      exp_q.delete();
      for (int k = 0; k < 4; k++) begin
         tr_q.push_back(22'h91 + 22'(k));
         exp_q.push_back(22'h91 + 22'(k));
      end
      load_tracker();
      wait_qe("en_query", 200);
      @(posedge clk); #1;
      enable = 1'b0;
      wait_idle("en_idle", 60);
      chk_rx("en_rx");
      exp_total += 4;
      chk("en_mig_count", mig_count, exp_total);
      q0 = qe_cnt;
      step(250);
      chk("en_no_query", qe_cnt - q0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mig_requester.md
MIG_REQUESTER -- requirements
Module: mig_requester

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 22, migration address width.
REQ-002 SHALL have parameter NUM_ENTRY, default 25, maximum addresses drained per epoch.
REQ-003 SHALL have parameter EPOCH_CYCLES, default 1000000, idle cycles between queries.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, maximum wait for query_ready.
REQ-005 SHALL have parameter FIFO_DEPTH, default 32, request buffer depth (power of 2).
REQ-006 clk  in  1  clock; all logic posedge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 enable  in  1  permits new epochs.
REQ-009 query_en  out  1  single-cycle query strobe to tracker.
REQ-010 query_ready  in  1  tracker top-K snapshot ready pulse.
REQ-011 mig_addr_en  in  1  tracker address-valid.
REQ-012 mig_addr  in  ADDR_SIZE  tracker head address.
REQ-013 mig_addr_ready  out  1  consumer ready; handshake = mig_addr_en & mig_addr_ready.
REQ-014 req_valid  out  1  migration request valid.
REQ-015 req_addr  out  ADDR_SIZE  migration request address.
REQ-016 req_ready  in  1  downstream accepts request.
REQ-017 busy  out  1  FSM not in IDLE or FIFO non-empty.
REQ-018 mig_count  out  16  total requests issued, saturating at 16'hFFFF.
REQ-019 timeout_err  out  1  sticky; set on query timeout.

Function
REQ-020 FSM SHALL have states IDLE, QUERY, WAIT, DRAIN.
REQ-021 IDLE: epoch counter increments while enable=1, held at 0 while enable=0; on count reaching EPOCH_CYCLES-1 with FIFO empty, go to QUERY and clear counter; if FIFO non-empty, counter holds at EPOCH_CYCLES-1 until empty.
REQ-022 QUERY: query_en=1 for exactly one cycle, next state WAIT; query_en=0 in all other states.
REQ-023 WAIT: on query_ready=1 go to DRAIN; after TIMEOUT_CYCLES cycles without it set timeout_err, go to IDLE.
REQ-024 DRAIN: mig_addr_ready = !fifo_full; mig_addr_ready=0 in all other states.
REQ-025 Each DRAIN handshake with mig_addr != all-ones SHALL push mig_addr into FIFO and increment drain count.
REQ-026 Handshake with mig_addr == all-ones (sentinel) SHALL NOT push and SHALL end DRAIN to IDLE.
REQ-027 DRAIN SHALL end to IDLE after NUM_ENTRY non-sentinel pushes, including the handshake cycle itself.
REQ-028 DRAIN SHALL wait indefinitely while mig_addr_en=0 or FIFO full.
REQ-029 FIFO pop side independent of FSM: req_valid = !fifo_empty, req_addr = FIFO head; pop on req_valid & req_ready.
REQ-030 Simultaneous push and pop SHALL be legal at any occupancy, including full (pop frees slot same cycle only for next cycle's ready).
REQ-031 req_addr SHALL remain stable while req_valid=1 and req_ready=0.
REQ-032 mig_count increments by 1 per popped request; saturates.
REQ-033 Latency: pushed address appears on req_addr the cycle after push when FIFO was empty.
REQ-034 enable deassert mid-epoch SHALL NOT abort QUERY/WAIT/DRAIN; it only blocks the next epoch.
REQ-035 busy SHALL equal (state != IDLE) | !fifo_empty, combinational.

Reset
REQ-036 On rst_n=0: state IDLE, epoch/timeout/drain counters 0, FIFO empty, mig_count 0, timeout_err 0.
REQ-037 Outputs during reset: query_en=0, mig_addr_ready=0, req_valid=0, req_addr=0, busy=0.
REQ-038 Reset mid-DRAIN SHALL discard buffered addresses; first epoch after release waits full EPOCH_CYCLES.

Structure
REQ-039 FSM state enum and sentinel constant SHALL live in shared package mig_pkg.
REQ-040 FIFO SHALL be one sub-module, sync_fifo (parameters WIDTH, DEPTH; full/empty flags).

Verification (bench params: EPOCH_CYCLES=100, NUM_ENTRY=4, FIFO_DEPTH=4, TIMEOUT_CYCLES=16)
REQ-041 enable=1, tracker supplies 0x10,0x20,0x30,0x40, req_ready=1 -> query_en pulse at cycle 100, four requests in order, mig_count=4, return to IDLE without sentinel.
REQ-042 Tracker supplies 0x11 then 0x3FFFFF -> one request 0x11, DRAIN exits on sentinel, mig_count=1.
REQ-043 req_ready=0, tracker offers 6 addresses -> mig_addr_ready drops after 4 pushes, no loss; release req_ready -> 4 requests in order, next epoch's query_en delayed until FIFO empty.
REQ-044 query_ready never asserted -> timeout_err=1 after 16 WAIT cycles, FSM IDLE, next epoch still queries.
REQ-045 Assert rst_n=0 in DRAIN with 2 entries buffered -> req_valid=0, mig_count=0 immediately; no query_en before 100 cycles post-release.
REQ-046 enable=0 during WAIT -> DRAIN completes normally, no further query_en while enable=0.
